// File: rtl/l1d_port_rr_arb_pkg.sv
// Shared types and helpers for the L1D port round-robin arbiter.
package l1d_arb_pkg;

    // Widest requester vector the index helper can encode.
    localparam int MAX_REQ = 32;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

    // Encodes a one-hot vector into its bit index by OR-ing the indices of
    // the set bits; the result is only meaningful for a one-hot input.
    function automatic int unsigned onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | unsigned'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/l1d_port_rr_arb_if.sv
// Requester-side and downstream-side handshake bundle of the L1D port arbiter.
interface l1d_port_rr_arb_if #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 64
);
    localparam int SRC_W = $clog2(N_REQ);

    logic [N_REQ-1:0]            req_valid_i;
    logic [N_REQ-1:0]            req_last_i;
    logic [N_REQ*DATA_WIDTH-1:0] req_data_i;
    logic [N_REQ-1:0]            req_ready_o;
    logic                        out_valid_o;
    logic                        out_ready_i;
    logic [DATA_WIDTH-1:0]       out_data_o;
    logic                        out_last_o;
    logic [SRC_W-1:0]            out_src_o;
    logic                        burst_err_o;

    // Requesters plus the downstream consumer.
    modport master (
        output req_valid_i, req_last_i, req_data_i, out_ready_i,
        input  req_ready_o, out_valid_o, out_data_o, out_last_o, out_src_o, burst_err_o
    );

    // The arbiter itself.
    modport slave (
        input  req_valid_i, req_last_i, req_data_i, out_ready_i,
        output req_ready_o, out_valid_o, out_data_o, out_last_o, out_src_o, burst_err_o
    );
endinterface

// File: rtl/l1d_port_rr_arb_rr_pick.sv
// Round-robin pick: first valid requester at or after rr_ptr, with wrap.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int SRC_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [SRC_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] gnt
);
    logic [2*N_REQ-1:0] dbl_valid;
    logic [2*N_REQ-1:0] dbl_gnt;
    logic               found;

    // The doubled vector turns the modulo search into a plain priority scan.
    assign dbl_valid = {valid, valid};

    // Priority search over the doubled vector starting at rr_ptr.
    always_comb begin
        dbl_gnt = '0;
        found   = 1'b0;
        for (int i = 0; i < 2*N_REQ; i++) begin
            if (!found && (i >= int'(rr_ptr)) && dbl_valid[i]) begin
                dbl_gnt[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign gnt = dbl_gnt[N_REQ-1:0] | dbl_gnt[2*N_REQ-1:N_REQ];
endmodule

// File: rtl/onehot_mux.sv
// AND-OR multiplexer selecting one packed source by a one-hot select.
module onehot_mux #(
    parameter int SOURCE_COUNT = 4,
    parameter int DATA_WIDTH   = 64
) (
    input  logic [SOURCE_COUNT-1:0]            sel,
    input  logic [SOURCE_COUNT*DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0]              data_out
);
    // OR together every source whose select bit is set.
    always_comb begin
        // NOTE: defaulting every always_comb output first keeps a path with no assignment from inferring a latch.
        data_out = '0;
        for (int i = 0; i < SOURCE_COUNT; i++) begin
            if (sel[i]) begin
                data_out = data_out | data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end
endmodule

// File: rtl/l1d_port_rr_arb.sv
// Round-robin arbiter with burst lock sharing one downstream L1D port.
module l1d_port_rr_arb
    import l1d_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BEATS  = 8,
    parameter int SRC_W      = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rstn,
    l1d_port_rr_arb_if.slave    bus
);
    localparam int CNT_W = $clog2(MAX_BEATS + 1);
    localparam int BEAT_W = DATA_WIDTH + 1;

    arb_state_e                 state;
    logic [SRC_W-1:0]           rr_ptr;
    logic [SRC_W-1:0]           owner;
    logic [CNT_W-1:0]           beat_cnt;

    logic [N_REQ-1:0]           pick_gnt;
    logic [N_REQ-1:0]           gnt;
    logic [N_REQ-1:0]           ready;
    logic                       can_load;
    logic                       accept;
    logic [SRC_W-1:0]           src;
    logic [SRC_W-1:0]           next_ptr;
    logic [CNT_W-1:0]           cnt_next;
    logic                       overlong;
    logic [N_REQ*BEAT_W-1:0]    mux_in;
    logic [BEAT_W-1:0]          sel_beat;
    logic                       beat_last;

    rr_pick #(.N_REQ(N_REQ), .SRC_W(SRC_W)) u_pick (
        .valid  (bus.req_valid_i),
        .rr_ptr (rr_ptr),
        .gnt    (pick_gnt)
    );

    // Each mux source carries the payload with its last flag on top.
    for (genvar j = 0; j < N_REQ; j++) begin : g_mux_in
        assign mux_in[j*BEAT_W +: BEAT_W] =
            {bus.req_last_i[j], bus.req_data_i[j*DATA_WIDTH +: DATA_WIDTH]};
    end

    onehot_mux #(.SOURCE_COUNT(N_REQ), .DATA_WIDTH(BEAT_W)) u_mux (
        .sel      (gnt),
        .data_in  (mux_in),
        .data_out (sel_beat)
    );

    // A locked owner keeps the grant even while its valid is low.
    always_comb begin
        gnt = pick_gnt;
        if (state == ARB_LOCKED) begin
            gnt = {{(N_REQ-1){1'b0}}, 1'b1} << owner;
        end
    end

    assign can_load       = !bus.out_valid_o || bus.out_ready_i;
    assign ready          = gnt & {N_REQ{can_load}};
    assign bus.req_ready_o = ready;
    assign accept         = |(bus.req_valid_i & ready);
    assign src            = SRC_W'(onehot_to_idx(MAX_REQ'(gnt)));
    assign beat_last      = sel_beat[DATA_WIDTH];

    // Explicit wrap so a non-power-of-two N_REQ never lands on an unused index.
    assign next_ptr = (src == SRC_W'(N_REQ - 1)) ? '0 : src + SRC_W'(1);
    assign cnt_next = (state == ARB_LOCKED) ? beat_cnt + CNT_W'(1) : CNT_W'(1);
    assign overlong = !beat_last && (cnt_next == CNT_W'(MAX_BEATS));

    // Burst-lock FSM, round-robin pointer and overlong-burst pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state           <= ARB_IDLE;
            rr_ptr          <= '0;
            owner           <= '0;
            beat_cnt        <= '0;
            bus.burst_err_o <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every register see pre-edge values, so ordering inside the block does not matter.
            bus.burst_err_o <= 1'b0;
            if (accept) begin
                if (beat_last) begin
                    state    <= ARB_IDLE;
                    beat_cnt <= '0;
                    rr_ptr   <= next_ptr;
                end else if (overlong) begin
                    bus.burst_err_o <= 1'b1;
                    state           <= ARB_IDLE;
                    beat_cnt        <= '0;
                    rr_ptr          <= next_ptr;
                end else begin
                    state    <= ARB_LOCKED;
                    owner    <= src;
                    beat_cnt <= cnt_next;
                end
            end
        end
    end

    // Single-entry output stage: load on accept, clear on a pop without reload.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: the payload registers are reset too, so the port shows a clean zero beat right after reset.
            bus.out_valid_o <= 1'b0;
            bus.out_data_o  <= '0;
            bus.out_last_o  <= 1'b0;
            bus.out_src_o   <= '0;
        end else if (accept) begin
            bus.out_valid_o <= 1'b1;
            bus.out_data_o  <= sel_beat[DATA_WIDTH-1:0];
            bus.out_last_o  <= beat_last;
            bus.out_src_o   <= src;
        end else if (bus.out_ready_i) begin
            bus.out_valid_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_l1d_port_rr_arb.sv
// Scoreboard bench for l1d_port_rr_arb against a cycle-level behavioural model.
module tb_l1d_port_rr_arb;
    localparam int N_REQ = 4;
    localparam int DW    = 64;
    localparam int MAXB  = 8;
    localparam int SRC_W = 2;

    typedef struct packed {
        logic [DW-1:0]    data;
        logic             last;
        logic [SRC_W-1:0] src;
    } beat_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    l1d_port_rr_arb_if #(.N_REQ(N_REQ), .DATA_WIDTH(DW)) bus ();

    l1d_port_rr_arb #(
        .N_REQ(N_REQ), .DATA_WIDTH(DW), .MAX_BEATS(MAXB), .SRC_W(SRC_W)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int    checks   = 0;
    int    failures = 0;
    beat_t sb[$];

    // Reference model state: lock owner, beats in current burst, next start index.
    bit m_locked = 0;
    int m_owner  = 0;
    int m_cnt    = 0;
    int m_ptr    = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; predicts grant, accept, queued beat and error pulse.
    task automatic drive_cycle(input logic [N_REQ-1:0] v, input logic [N_REQ-1:0] l, input bit rdy);
        logic [DW-1:0]    d [N_REQ];
        logic [N_REQ-1:0] exp_rdy;
        int               src;
        bit               acc;
        bit               exp_err;
        beat_t            pend;
        int               n;
        @(negedge clk);
        for (int j = 0; j < N_REQ; j++) begin
            d[j] = {$urandom, $urandom};
            bus.req_data_i[j*DW +: DW] = d[j];
        end
        bus.req_valid_i = v;
        bus.req_last_i  = l;
        bus.out_ready_i = rdy;
        #1;
        src = -1;
        if (m_locked) begin
            src = m_owner;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                if (src < 0 && v[(m_ptr + k) % N_REQ]) src = (m_ptr + k) % N_REQ;
            end
        end
        exp_rdy = '0;
        if (src >= 0 && (sb.size() == 0 || rdy)) exp_rdy[src] = 1'b1;
        check("req_ready", bus.req_ready_o, exp_rdy);
        acc     = (src >= 0) && v[src] && exp_rdy[src];
        exp_err = 0;
        pend    = '0;
        if (acc) begin
            pend = '{data: d[src], last: l[src], src: SRC_W'(src)};
            n    = m_locked ? m_cnt + 1 : 1;
            if (l[src]) begin
                m_locked = 0; m_cnt = 0; m_ptr = (src + 1) % N_REQ;
            end else if (n == MAXB) begin
                exp_err = 1; m_locked = 0; m_cnt = 0; m_ptr = (src + 1) % N_REQ;
            end else begin
                m_locked = 1; m_owner = src; m_cnt = n;
            end
        end
        @(posedge clk);
        #1;
        if (acc) sb.push_back(pend);
        check("burst_err", bus.burst_err_o, exp_err);
    endtask

    // Monitor: compares the presented beat with the scoreboard head, pops on handshake.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            check("out_valid", bus.out_valid_o, sb.size() != 0);
            if (bus.out_valid_o && sb.size() != 0) begin
                check("out_data", bus.out_data_o, sb[0].data);
                check("out_last", bus.out_last_o, sb[0].last);
                check("out_src",  bus.out_src_o,  sb[0].src);
                if (bus.out_ready_i) void'(sb.pop_front());
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, bus.out_valid_o, 1'b0);
        check({tag, "_data"},  bus.out_data_o,  '0);
        check({tag, "_last"},  bus.out_last_o,  1'b0);
        check({tag, "_src"},   bus.out_src_o,   '0);
        check({tag, "_err"},   bus.burst_err_o, 1'b0);
    endtask

    initial begin
        bus.req_valid_i = '0;
        bus.req_last_i  = '0;
        bus.req_data_i  = '0;
        bus.out_ready_i = 1'b0;
        #1;
        check_reset_outputs("rst");
        check("rst_ready", bus.req_ready_o, '0);
        #12;
        rstn = 1'b1;

        // Fairness: everyone valid, single-beat bursts.
        repeat (12) drive_cycle(4'hF, 4'hF, 1'b1);

        // Burst lock: req1 3-beat burst while req0/req2 wait.
        drive_cycle(4'b0010, 4'b0000, 1'b1);
        drive_cycle(4'b0111, 4'b0000, 1'b1);
        drive_cycle(4'b0111, 4'b0010, 1'b1);
        repeat (2) drive_cycle(4'b0101, 4'b0101, 1'b1);

        // Backpressure then pop-and-reload.
        drive_cycle(4'b0001, 4'b0001, 1'b1);
        repeat (5) drive_cycle(4'b0011, 4'b0011, 1'b0);
        repeat (2) drive_cycle(4'b0011, 4'b0011, 1'b1);

        // Owner stall: req2 holds the lock while idle.
        drive_cycle(4'b0100, 4'b0000, 1'b1);
        repeat (4) drive_cycle(4'b1000, 4'b1000, 1'b1);
        drive_cycle(4'b1100, 4'b0100, 1'b1);
        repeat (2) drive_cycle(4'b1000, 4'b1000, 1'b1);

        // Overlong burst from req0 with req1 waiting.
        drive_cycle(4'b0001, 4'b0000, 1'b1);
        repeat (9) drive_cycle(4'b0011, 4'b0010, 1'b1);
        repeat (3) drive_cycle(4'b0000, 4'b0000, 1'b1);

        // Asynchronous reset in the middle of a burst.
        repeat (2) drive_cycle(4'b0010, 4'b0000, 1'b1);
        #1;
        rstn = 1'b0;
        bus.req_valid_i = '0;
        #1;
        check_reset_outputs("arst");
        sb.delete();
        m_locked = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
        @(negedge clk);
        #3;
        rstn = 1'b1;
        repeat (4) drive_cycle(4'hF, 4'hF, 1'b1);

        // Random traffic, short bursts then long bursts.
        repeat (400) drive_cycle(4'($urandom), 4'($urandom & $urandom), $urandom_range(0, 3) != 0);
        repeat (300) drive_cycle(4'($urandom), 4'($urandom & $urandom & $urandom & $urandom),
                                 $urandom_range(0, 3) != 0);

        // Drain.
        repeat (4) drive_cycle(4'b0000, 4'b0000, 1'b1);
        check("drain", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/l1d_port_rr_arb.md
Name: l1d_port_rr_arb

Overview:
Round-robin arbiter with burst lock that shares one downstream L1D port (e.g. the refill/writeback bus toward L2) among N_REQ requesters. It produces a one-hot grant, uses it to select one requester's beat via the team's one-hot mux, and registers the selected beat into a single-entry output stage with a valid/ready handshake. Multi-beat bursts are never interleaved.

Parameters:
N_REQ, 4, number of requesters (>=2)
DATA_WIDTH, 64, payload width per beat
MAX_BEATS, 8, maximum legal beats per burst (>=1)
SRC_W, $clog2(N_REQ), width of the source index

Ports:
clk  input  1  clock, rising edge
rstn  input  1  asynchronous active-low reset
req_valid_i  input  N_REQ  per-requester beat valid
req_last_i  input  N_REQ  per-requester last beat of burst
req_data_i  input  N_REQ*DATA_WIDTH  packed payloads; requester j occupies bits [j*DATA_WIDTH +: DATA_WIDTH]
req_ready_o  output  N_REQ  per-requester beat accepted
out_valid_o  output  1  output stage holds a beat
out_ready_i  input  1  downstream accepts the beat
out_data_o  output  DATA_WIDTH  registered payload
out_last_o  output  1  registered last flag
out_src_o  output  SRC_W  index of the requester that sourced the beat
burst_err_o  output  1  one-cycle pulse: burst exceeded MAX_BEATS and its lock was forcibly released

Behaviour:
- Reset (rstn=0, async): state=IDLE, rr_ptr=0, owner=0, beat_cnt=0, out_valid_o=0, out_data_o=0, out_last_o=0, out_src_o=0, burst_err_o=0. Reset mid-burst discards the burst; no beat is replayed.
- can_load = !out_valid_o | out_ready_i.
- IDLE grant: one-hot gnt = first j with req_valid_i[j]=1, searching j = rr_ptr, rr_ptr+1, ... modulo N_REQ. If no requester is valid, gnt=0.
- LOCKED grant: gnt = onehot(owner), regardless of req_valid_i. All other requesters are stalled.
- req_ready_o = gnt & {N_REQ{can_load}}. This path is combinational; there is no dependence on req_ready_o inside the block.
- A beat is accepted when |(req_valid_i & req_ready_o). On accept, the output stage loads in the same edge: data is the one-hot-mux selection of req_data_i by gnt, out_last_o is req_last_i[src], out_src_o is the encoded gnt, and out_valid_o=1. Latency is 1 cycle from accept to out_valid_o.
- Output-stage pop when out_valid_o & out_ready_i. If a pop and an accept happen in the same cycle, the stage reloads and out_valid_o stays 1. A pop with no accept clears out_valid_o. The stage holds its contents while out_ready_i=0.
- Full throughput: 1 beat/cycle while out_ready_i=1.
- FSM, IDLE -> LOCKED: on accept with last=0. Set owner=src and beat_cnt=1.
- FSM, LOCKED -> LOCKED: on accept with last=0. Increment beat_cnt.
- FSM, LOCKED -> IDLE: on accept with last=1.
- FSM, IDLE -> IDLE: on accept with last=1 (single-beat burst).
- rr_ptr update: on every accept with last=1, rr_ptr = (src+1) mod N_REQ. rr_ptr does not change mid-burst.
- Overlong burst: if in LOCKED an accept with last=0 would make beat_cnt == MAX_BEATS, the beat is still passed through. Then burst_err_o=1 for one cycle, state returns to IDLE, and rr_ptr = (owner+1) mod N_REQ. The requester's remaining beats are subsequently treated as new bursts.
- MAX_BEATS=1: every beat with last=0 triggers burst_err_o, and the FSM never enters LOCKED.
- An owner that deasserts valid mid-burst holds the lock; the port idles and does not time out.
- out_src_o width rule: SRC_W=$clog2(N_REQ). N_REQ that is not a power of two is legal; rr_ptr wrap uses an explicit compare, not truncation.

Decomposition:
- Package l1d_arb_pkg holds the state enum (ARB_IDLE, ARB_LOCKED) and a helper function onehot_to_idx.
- Sub-module rr_pick, combinational: (valid vector, rr_ptr) -> one-hot grant. It is implemented as a double-width priority search.
- Payload selection instantiates the existing onehot_mux with SOURCE_COUNT=N_REQ and DATA_WIDTH=DATA_WIDTH+1 (payload plus last).

Test Plan:
- Fairness: all 4 requesters continuously valid with single-beat bursts (last=1), out_ready_i=1 -> out_src_o sequence 0,1,2,3,0,1,...; each req_ready_o is asserted 1 cycle in 4.
- Burst lock: req1 sends a 3-beat burst (last on beat 3) while req0 and req2 are valid -> out_src_o=1,1,1, then 2, then 0; req0 and req2 req_ready_o stay 0 during the burst.
- Backpressure: out_ready_i=0 for 5 cycles with out_valid_o=1 -> all req_ready_o=0 and out_data_o is stable. Raising out_ready_i with a pending request -> pop and reload in the same cycle, out_valid_o stays 1.
- Owner stall: req2 sends beat 1 (last=0), drops valid for 4 cycles, req3 is valid -> no beat from req3 is accepted. When req2 resumes with last=1, the lock is released and req3 is granted next.
- Overlong burst: MAX_BEATS=8, req0 sends 10 beats with last=0 -> burst_err_o pulses once, coincident with the cycle after the 8th beat is accepted. req1 (waiting) is granted next.
- Async reset: assert rstn=0 mid-burst between clock edges -> outputs go to their reset values immediately. After release, grants start from rr_ptr=0.
